// File: rtl/rf_scheduler.sv
// rf_scheduler: slot scheduler in front of the two-phase RV32I register file.
// The register file offers one 2-read/1-write access every two clocks; this
// block aligns core reads, writebacks and debug accesses to its slot cycles
// (phase==0), tracks pending destinations in a 31-bit scoreboard and forwards
// same-slot write data into read responses.
// Build option: define RF_DEBUG_EN to build the debug port arbitration,
// its starvation counters and the dbg_ack/dbg_rdata path.
module rf_scheduler #(
    parameter int XLEN       = 32,
    parameter int DBG_STARVE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_valid,
    output logic            rd_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rs1_v,
    output logic [XLEN-1:0] rsp_rs2_v,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_v,
    input  logic            dbg_req,
    input  logic            dbg_we,
    input  logic [4:0]      dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic            dbg_ack,
    output logic [XLEN-1:0] dbg_rdata,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_rd_v,
    output logic            rf_we,
    input  logic [XLEN-1:0] rf_rs1_v,
    input  logic [XLEN-1:0] rf_rs2_v,
    output logic            rf_rst_n
);

    logic            phase;
    logic            slot;
    logic [31:1]     pending;
    logic [31:0]     pend_vec;
    logic [31:0]     sb_set;
    logic [31:0]     sb_clr;
    logic            dbg_rd_win;
    logic            dbg_wr_win;
    logic            core_rd_win;
    logic            core_wb_win;
    logic            rs1_haz;
    logic            rs2_haz;
    logic            read_go;
    logic            write_go;
    logic [4:0]      rd_a1;
    logic [4:0]      rd_a2;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [4:0]      hold_rs1;
    logic [4:0]      hold_rs2;
    logic            s1_valid;
    logic            s1_fwd_v;
    logic [4:0]      s1_fwd_rd;
    logic [XLEN-1:0] s1_fwd_data;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    assign rf_rst_n = ~rst;
    assign slot     = ~phase;

    // Phase tracker mirroring the register file; slot cycles are phase==0.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase <= 1'b1;
        else     phase <= ~phase;
    end

`ifdef RF_DEBUG_EN
    localparam int CNT_W = (DBG_STARVE < 1) ? 1 : $clog2(DBG_STARVE + 1);

    logic [CNT_W-1:0] rd_starve;
    logic [CNT_W-1:0] wr_starve;
    logic             dbg_idle;
    logic             dbg_rd_req;
    logic             dbg_wr_req;
    logic             s1_dbg_rd;
    logic             s1_dbg_wr;

    // A debug request is held high until its ack, so it must not re-arbitrate while in flight.
    assign dbg_idle   = ~s1_dbg_rd & ~s1_dbg_wr & ~dbg_ack;
    assign dbg_rd_req = dbg_req & ~dbg_we & dbg_idle;
    assign dbg_wr_req = dbg_req &  dbg_we & dbg_idle;
    assign dbg_rd_win = dbg_rd_req & (~rd_valid | (rd_starve >= CNT_W'(DBG_STARVE)));
    assign dbg_wr_win = dbg_wr_req & (~wb_valid | (wr_starve >= CNT_W'(DBG_STARVE)));

    // Starvation counters: count slots the debug port lost, clear when it wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_starve <= '0;
            wr_starve <= '0;
        end else if (slot) begin
            if (dbg_rd_win)
                rd_starve <= '0;
            else if (dbg_rd_req && (rd_starve < CNT_W'(DBG_STARVE)))
                rd_starve <= rd_starve + CNT_W'(1);
            if (dbg_wr_win)
                wr_starve <= '0;
            else if (dbg_wr_req && (wr_starve < CNT_W'(DBG_STARVE)))
                wr_starve <= wr_starve + CNT_W'(1);
        end
    end

    // Debug completion pipeline: ack two cycles after the winning slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_dbg_rd <= 1'b0;
            s1_dbg_wr <= 1'b0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            s1_dbg_rd <= slot & dbg_rd_win;
            s1_dbg_wr <= slot & dbg_wr_win;
            dbg_ack   <= s1_dbg_rd | s1_dbg_wr;
            if (s1_dbg_rd) dbg_rdata <= fwd1;
        end
    end
`else
    logic unused_dbg;

    assign unused_dbg = ^{dbg_req, dbg_we, dbg_addr, dbg_wdata, (DBG_STARVE > 0)};
    assign dbg_rd_win = 1'b0;
    assign dbg_wr_win = 1'b0;
    assign dbg_ack    = 1'b0;
    assign dbg_rdata  = '0;
`endif

    assign core_rd_win = rd_valid & ~dbg_rd_win;
    assign core_wb_win = wb_valid & ~dbg_wr_win;

    // A pending source stalls the read unless this very slot commits it.
    assign pend_vec = {pending, 1'b0};
    assign wb_ready = slot & core_wb_win;
    assign rs1_haz  = (rs1 != 5'd0) & pend_vec[rs1] & ~(wb_ready & (wb_rd == rs1));
    assign rs2_haz  = (rs2 != 5'd0) & pend_vec[rs2] & ~(wb_ready & (wb_rd == rs2));
    assign rd_ready = slot & core_rd_win & ~rs1_haz & ~rs2_haz;

    assign read_go  = rd_ready | (slot & dbg_rd_win);
    assign write_go = wb_ready | (slot & dbg_wr_win);
    assign rd_a1    = dbg_rd_win ? dbg_addr  : rs1;
    assign rd_a2    = dbg_rd_win ? dbg_addr  : rs2;
    assign wr_addr  = dbg_wr_win ? dbg_addr  : wb_rd;
    assign wr_data  = dbg_wr_win ? dbg_wdata : wb_v;

    // Writes to x0 are accepted but never reach the register file.
    assign rf_we   = write_go & (wr_addr != 5'd0);
    assign rf_rd   = write_go ? wr_addr : 5'd0;
    assign rf_rd_v = write_go ? wr_data : '0;
    assign rf_rs1  = read_go ? rd_a1 : hold_rs1;
    assign rf_rs2  = read_go ? rd_a2 : hold_rs2;

    // Read stage 1: hold issued addresses and capture the same-slot write for forwarding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_rs1    <= 5'd0;
            hold_rs2    <= 5'd0;
            s1_valid    <= 1'b0;
            s1_fwd_v    <= 1'b0;
            s1_fwd_rd   <= 5'd0;
            s1_fwd_data <= '0;
        end else begin
            s1_valid    <= rd_ready;
            s1_fwd_v    <= rf_we;
            s1_fwd_rd   <= rf_rd;
            s1_fwd_data <= rf_rd_v;
            if (read_go) begin
                hold_rs1 <= rd_a1;
                hold_rs2 <= rd_a2;
            end
        end
    end

    // Forwarding mux: a same-slot write overrides the stale register file data; x0 reads 0.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        fwd1 = rf_rs1_v;
        fwd2 = rf_rs2_v;
        if (s1_fwd_v && (s1_fwd_rd == hold_rs1)) fwd1 = s1_fwd_data;
        if (s1_fwd_v && (s1_fwd_rd == hold_rs2)) fwd2 = s1_fwd_data;
        if (hold_rs1 == 5'd0) fwd1 = '0;
        if (hold_rs2 == 5'd0) fwd2 = '0;
    end

    // Read stage 2: one-cycle response pulse, data held until the next response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rs1_v <= '0;
            rsp_rs2_v <= '0;
        end else begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_rs1_v <= fwd1;
                rsp_rs2_v <= fwd2;
            end
        end
    end

    // Scoreboard set/clear masks; a write to a register clears it, an issue sets it.
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (iss_valid && (iss_rd != 5'd0)) sb_set[iss_rd] = 1'b1;
        if (rf_we)                         sb_clr[rf_rd]  = 1'b1;
    end

    // Scoreboard update; applying the set after the clear lets a same-cycle issue win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~sb_clr[31:1]) | sb_set[31:1];
    end

endmodule

// File: tb/tb_rf_scheduler.sv
// tb_rf_scheduler: directed self-checking bench for rf_scheduler with a small
// two-phase register file model (read registered in the slot, write committed
// at the end of the following cycle).
module tb_rf_scheduler;

    localparam int XLEN       = 32;
    localparam int DBG_STARVE = 4;

    logic            clk;
    logic            rst;
    logic            rd_valid;
    logic            rd_ready;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rs1_v;
    logic [XLEN-1:0] rsp_rs2_v;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_v;
    logic            dbg_req;
    logic            dbg_we;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_wdata;
    logic            dbg_ack;
    logic [XLEN-1:0] dbg_rdata;
    logic [4:0]      rf_rs1;
    logic [4:0]      rf_rs2;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_rd_v;
    logic            rf_we;
    logic [XLEN-1:0] rf_rs1_v;
    logic [XLEN-1:0] rf_rs2_v;
    logic            rf_rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    rf_scheduler #(.XLEN(XLEN), .DBG_STARVE(DBG_STARVE)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rsp_valid (rsp_valid),
        .rsp_rs1_v (rsp_rs1_v),
        .rsp_rs2_v (rsp_rs2_v),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_v      (wb_v),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .rf_rs1    (rf_rs1),
        .rf_rs2    (rf_rs2),
        .rf_rd     (rf_rd),
        .rf_rd_v   (rf_rd_v),
        .rf_we     (rf_we),
        .rf_rs1_v  (rf_rs1_v),
        .rf_rs2_v  (rf_rs2_v),
        .rf_rst_n  (rf_rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent phase model used only to align stimulus to slot cycles.
    logic tb_phase;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_phase <= 1'b1;
        else     tb_phase <= ~tb_phase;
    end

    // Register file model: read registered at the slot edge, write commits one cycle later.
    bit   [31:0] rf_mem [32];
    logic        wq_v;
    logic [4:0]  wq_rd;
    logic [31:0] wq_d;
    always @(posedge clk or negedge rf_rst_n) begin
        if (!rf_rst_n) begin
            wq_v     <= 1'b0;
            wq_rd    <= 5'd0;
            wq_d     <= '0;
            rf_rs1_v <= '0;
            rf_rs2_v <= '0;
        end else begin
            if (wq_v && (wq_rd != 5'd0)) rf_mem[wq_rd] <= wq_d;
            wq_v     <= rf_we;
            wq_rd    <= rf_rd;
            wq_d     <= rf_rd_v;
            rf_rs1_v <= rf_mem[rf_rs1];
            rf_rs2_v <= rf_mem[rf_rs2];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle();
        rd_valid  = 1'b0;
        rs1       = 5'd0;
        rs2       = 5'd0;
        iss_valid = 1'b0;
        iss_rd    = 5'd0;
        wb_valid  = 1'b0;
        wb_rd     = 5'd0;
        wb_v      = '0;
        dbg_req   = 1'b0;
        dbg_we    = 1'b0;
        dbg_addr  = 5'd0;
        dbg_wdata = '0;
    endtask

    task automatic to_slot();
        do next_cycle(); while (tb_phase != 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        settle();
        check("rst_rd_ready",  32'(rd_ready),  32'd0);
        check("rst_wb_ready",  32'(wb_ready),  32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rf_we",     32'(rf_we),     32'd0);
        check("rst_rf_rs1",    32'(rf_rs1),    32'd0);
        check("rst_dbg_ack",   32'(dbg_ack),   32'd0);
        check("rst_rf_rst_n",  32'(rf_rst_n),  32'd0);

        // Reset release with a held x0/x0 read: first accept in the first slot.
        next_cycle();
        rst = 1'b0;
        rd_valid = 1'b1;
        settle();
        check("t1_ready_phase1", 32'(rd_ready), 32'd0);
        check("t1_rf_rst_n",     32'(rf_rst_n), 32'd1);
        next_cycle();
        settle();
        check("t1_ready_slot", 32'(rd_ready), 32'd1);
        next_cycle();
        rd_valid = 1'b0;
        settle();
        check("t1_rsp_early", 32'(rsp_valid), 32'd0);
        next_cycle();
        settle();
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_rs1",   rsp_rs1_v,      32'd0);
        check("t1_rsp_rs2",   rsp_rs2_v,      32'd0);
        next_cycle();
        settle();
        check("t1_rsp_pulse", 32'(rsp_valid), 32'd0);

        // Same-slot writeback of x5 forwarded into a read of x5/x5.
        idle();
        to_slot();
        wb_valid = 1'b1; wb_rd = 5'd5; wb_v = 32'hDEAD_BEEF;
        rd_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd5;
        settle();
        check("t2_wb_ready", 32'(wb_ready), 32'd1);
        check("t2_rd_ready", 32'(rd_ready), 32'd1);
        check("t2_rf_we",    32'(rf_we),    32'd1);
        check("t2_rf_rd",    32'(rf_rd),    32'd5);
        check("t2_rf_rd_v",  rf_rd_v,       32'hDEAD_BEEF);
        next_cycle();
        idle();
        settle();
        check("t2_rf_we_off", 32'(rf_we), 32'd0);
        next_cycle();
        rd_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd0;
        settle();
        check("t2_rsp_valid",  32'(rsp_valid), 32'd1);
        check("t2_fwd_rs1",    rsp_rs1_v,      32'hDEAD_BEEF);
        check("t2_fwd_rs2",    rsp_rs2_v,      32'hDEAD_BEEF);
        check("t2_rd_ready_b", 32'(rd_ready),  32'd1);
        next_cycle();
        idle();
        next_cycle();
        settle();
        check("t2_rf_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t2_rf_rs1",       rsp_rs1_v,      32'hDEAD_BEEF);
        check("t2_rf_rs2_x0",    rsp_rs2_v,      32'd0);

        // Issue x7, then a read of x7 stalls until the writeback of x7 is accepted.
        next_cycle();
        iss_valid = 1'b1; iss_rd = 5'd7;
        next_cycle();
        idle();
        to_slot();
        rd_valid = 1'b1; rs1 = 5'd7; rs2 = 5'd0;
        settle();
        check("t3_stall_a", 32'(rd_ready), 32'd0);
        to_slot();
        settle();
        check("t3_stall_b", 32'(rd_ready), 32'd0);
        to_slot();
        wb_valid = 1'b1; wb_rd = 5'd7; wb_v = 32'h1234_5678;
        settle();
        check("t3_wb_ready", 32'(wb_ready), 32'd1);
        check("t3_rd_ready", 32'(rd_ready), 32'd1);
        next_cycle();
        idle();
        next_cycle();
        settle();
        check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t3_rsp_rs1",   rsp_rs1_v,      32'h1234_5678);

        // Issue and writeback of x3 in the same slot: the issue wins, x3 stays pending.
        idle();
        to_slot();
        iss_valid = 1'b1; iss_rd = 5'd3;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_v = 32'hA5A5_A5A5;
        settle();
        check("t4_wb_ready", 32'(wb_ready), 32'd1);
        next_cycle();
        idle();
        to_slot();
        rd_valid = 1'b1; rs1 = 5'd3;
        settle();
        check("t4_x3_stall", 32'(rd_ready), 32'd0);
        next_cycle();
        idle();
        to_slot();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_v = 32'h0BAD_F00D;
        settle();
        check("t4_wb2_ready", 32'(wb_ready), 32'd1);
        next_cycle();
        idle();
        to_slot();
        rd_valid = 1'b1; rs1 = 5'd3;
        settle();
        check("t4_x3_ready", 32'(rd_ready), 32'd1);
        next_cycle();
        idle();
        next_cycle();
        settle();
        check("t4_x3_rsp", rsp_rs1_v, 32'h0BAD_F00D);

        // Writeback to x0 is accepted without a register file write; no accept outside a slot.
        idle();
        to_slot();
        wb_valid = 1'b1; wb_rd = 5'd0; wb_v = 32'hFFFF_FFFF;
        settle();
        check("t5_x0_wb_ready", 32'(wb_ready), 32'd1);
        check("t5_x0_rf_we",    32'(rf_we),    32'd0);
        next_cycle();
        settle();
        check("t5_offslot_wb_ready", 32'(wb_ready), 32'd0);

        // Reset between acceptance and response drops the response; phase restarts at 1.
        idle();
        to_slot();
        rd_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd0;
        settle();
        check("t6_accept", 32'(rd_ready), 32'd1);
        next_cycle();
        rst = 1'b1;
        settle();
        check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_rst_rf_rs1",    32'(rf_rs1),    32'd0);
        check("t6_rst_rd_ready",  32'(rd_ready),  32'd0);
        next_cycle();
        rst = 1'b0;
        settle();
        check("t6_rel_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_rel_phase1",    32'(rd_ready),  32'd0);
        next_cycle();
        settle();
        check("t6_first_slot", 32'(rd_ready),  32'd1);
        check("t6_no_rsp",     32'(rsp_valid), 32'd0);
        next_cycle();
        idle();
        settle();
        check("t6_no_rsp_b", 32'(rsp_valid), 32'd0);
        next_cycle();
        settle();
        check("t6_new_rsp",     32'(rsp_valid), 32'd1);
        check("t6_new_rsp_rs1", rsp_rs1_v,      32'hDEAD_BEEF);

`ifdef RF_DEBUG_EN
        // Debug read of x5 against continuous core reads: debug wins the 5th slot.
        idle();
        to_slot();
        for (int k = 1; k <= 5; k++) begin
            rd_valid = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
            dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
            settle();
            check($sformatf("t7_slot%0d_core", k), 32'(rd_ready), (k < 5) ? 32'd1 : 32'd0);
            check($sformatf("t7_slot%0d_ack", k),  32'(dbg_ack),  32'd0);
            if (k < 5) to_slot();
        end
        check("t7_rf_rs1_dbg", 32'(rf_rs1), 32'd5);
        next_cycle();
        settle();
        check("t7_ack_early", 32'(dbg_ack), 32'd0);
        next_cycle();
        settle();
        check("t7_ack",       32'(dbg_ack),   32'd1);
        check("t7_rdata",     dbg_rdata,      32'hDEAD_BEEF);
        check("t7_no_rsp",    32'(rsp_valid), 32'd0);
        check("t7_core_back", 32'(rd_ready),  32'd1);
        next_cycle();
        idle();
        settle();
        check("t7_ack_pulse", 32'(dbg_ack), 32'd0);

        // Debug write of x9 with no competing writeback wins at once.
        to_slot();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h600D_F00D;
        settle();
        check("t8_rf_we",   32'(rf_we),    32'd1);
        check("t8_rf_rd",   32'(rf_rd),    32'd9);
        check("t8_rf_rd_v", rf_rd_v,       32'h600D_F00D);
        check("t8_wb_rdy",  32'(wb_ready), 32'd0);
        next_cycle();
        settle();
        check("t8_ack_early", 32'(dbg_ack), 32'd0);
        next_cycle();
        settle();
        check("t8_ack", 32'(dbg_ack), 32'd1);
        next_cycle();
        idle();
`else
        // Without the debug build the debug port is ignored entirely.
        idle();
        to_slot();
        for (int k = 1; k <= 5; k++) begin
            rd_valid = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
            dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
            settle();
            check($sformatf("t7_slot%0d_core", k), 32'(rd_ready), 32'd1);
            check($sformatf("t7_slot%0d_ack", k),  32'(dbg_ack),  32'd0);
            if (k < 5) to_slot();
        end
        next_cycle();
        next_cycle();
        settle();
        check("t7_core_rsp", 32'(rsp_valid), 32'd1);
        check("t7_no_ack",   32'(dbg_ack),   32'd0);
        check("t7_rdata",    dbg_rdata,      32'd0);
        idle();
        to_slot();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h600D_F00D;
        settle();
        check("t8_no_rf_we", 32'(rf_we), 32'd0);
        next_cycle();
        next_cycle();
        settle();
        check("t8_no_ack", 32'(dbg_ack), 32'd0);
        idle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
